wb_load_stage: RTL and testbench
================================

// Module: wb_load_stage
// PURPOSE
//   Writeback stage sitting directly upstream of the register file write port.
//   Accepts retiring MEM-stage results on a valid/ready handshake.
//   For loads, waits for the data-memory response, then performs byte/half extraction and LWL/LWR merge.
//   Drives the registered wreg/waddr/wdata triple consumed by the register file, one write per instruction.
// PARAMETERS
//   DATA_W  32  datapath width (only 32 is supported)
//   RADDR_W 5   register address width
// PORTS
//   clk            in   1       clock
//   resetn         in   1       synchronous, active-low reset
//   in_valid       in   1       MEM stage presents a retiring instruction
//   in_ready       out  1       stage can accept this cycle
//   in_wreg        in   1       instruction writes a GPR
//   in_waddr       in   5       destination GPR
//   in_wdata       in   32      ALU result; for loads, old value of rt (LWL/LWR merge source)
//   in_is_load     in   1       instruction is a load; data comes from mem_rdata
//   in_ld_op       in   3       0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 treated as LW
//   in_addr_lo     in   2       effective address bits [1:0]
//   mem_rsp_valid  in   1       data-memory read response valid (single-cycle pulse)
//   mem_rdata      in   32      aligned 32-bit word, little-endian
//   flush          in   1       exception/ERET flush; squash everything not yet written
//   wreg           out  1       register-file write enable (one-cycle pulse)
//   waddr          out  5       register-file write address
//   wdata          out  32      register-file write data
//   load_busy      out  1       state != IDLE; used by hazard unit to stall dependents
// BEHAVIOUR
//   Reset
//     - resetn=0 at posedge: state=IDLE, wreg=0, waddr=0, wdata=0, held regs cleared.
//     - in_ready=0 while resetn=0; load_busy=0.
//     - Reset mid-load abandons the outstanding response; a late mem_rsp_valid in IDLE is ignored.
//   States: IDLE, WAIT (load outstanding), DRAIN (flushed load, response still owed).
//   Handshake
//     - in_ready = resetn && state==IDLE.
//     - Accept = in_valid && in_ready && !flush.
//   Non-load accept at edge N
//     - wreg=in_wreg && in_waddr!=0, waddr/wdata registered; visible cycle N+1, written at edge N+1.
//   Load accept at edge N
//     - Latch waddr, old-rt, ld_op, addr_lo, wreg; go to WAIT; wreg=0 next cycle.
//     - mem_rsp_valid in WAIT at edge M: wdata=extract(mem_rdata), wreg=latched wreg && waddr!=0, go IDLE.
//       Min load latency: accept edge N, rsp at N+1 -> wreg high cycle N+2.
//     - A response arriving the same cycle as the load is accepted in IDLE is NOT consumed.
//       Memory guarantees >=1 cycle latency.
//   wreg is a single-cycle pulse; deasserted the cycle after any write unless a new accept occurs.
//   Back-to-back non-loads give one write per cycle.
//   Extract (b = byte at addr_lo, h = half at addr_lo[1], m = mem_rdata, r = old rt)
//     - LB: sign-extend b. LBU: zero-extend b.
//     - LH: sign-extend h. LHU: zero-extend h. addr_lo[0] ignored; misalignment is trapped upstream.
//     - LW: m, addr_lo ignored.
//     - LWL lo=0 {m[7:0],r[23:0]}; 1 {m[15:0],r[15:0]}; 2 {m[23:0],r[7:0]}; 3 m.
//     - LWR lo=0 m; 1 {r[31:24],m[31:8]}; 2 {r[31:16],m[31:16]}; 3 {r[31:8],m[31:24]}.
//   Flush
//     - IDLE: same-cycle input dropped; wreg=0 next cycle.
//     - WAIT without rsp: go DRAIN.
//     - WAIT with rsp: discard, go IDLE.
//     - DRAIN: stay until rsp, discard it, go IDLE.
//     - A write already registered (wreg high this cycle) is committed; flush does not cancel it.
// STRUCTURE
//   - Shared package/define: LD_LB..LD_LWR encodings, state encodings, RstEnable/WriteEnable/ZeroWord.
//   - One sub-module: load_align (pure combinational extract/merge: ld_op, addr_lo, m, r -> data).
//   - FSM plus output registers live in the top.
// TESTING
//   1. ADDU to $3 = 0x12345678 accepted -> next cycle wreg=1, waddr=3, wdata=0x12345678; following cycle wreg=0.
//   2. LB lo=2, m=0x00F00000 -> wdata=0xFFFFFFF0. LBU -> 0x000000F0. LHU lo=2, m=0x8001_0000 -> 0x00008001.
//   3. LWL lo=1, m=0xAABBCCDD, r=0x11223344 -> 0xCCDD3344. LWR lo=1 same inputs -> 0x11AABBCC.
//   4. Load, rsp delayed 3 cycles -> in_ready=0 and load_busy=1 for 3 cycles; single wreg pulse after rsp.
//   5. Load, flush in WAIT, rsp 2 cycles later -> no wreg ever; in_ready returns 1 the cycle after rsp.
//   6. in_waddr=0 non-load -> wreg stays 0. resetn=0 mid-WAIT -> wreg=0, IDLE; stray rsp ignored.

Source files
------------

// File: rtl/wb_load_stage_pkg.sv
// Shared definitions for the writeback/load stage.
//   - LD_* : load operation encodings carried on in_ld_op
//   - wb_state_e : writeback FSM states
//   - RstEnable / WriteEnable / ZeroWord : common level and value constants
package wb_load_stage_pkg;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

  localparam logic        RstEnable   = 1'b0;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/wb_load_stage_load_align.sv
// Combinational load extract/merge.
//   ld_op   : load operation (LD_* encoding; 7 behaves as LW)
//   addr_lo : effective address bits [1:0]
//   m       : aligned little-endian memory word
//   r       : old rt value, merge source for LWL/LWR
//   data    : value to write back
module wb_load_stage_load_align
  import wb_load_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = m[7:0];
    case (addr_lo)
      2'd0: b = m[7:0];
      2'd1: b = m[15:8];
      2'd2: b = m[23:16];
      2'd3: b = m[31:24];
      default: b = m[7:0];
    endcase
    // addr_lo[0] is ignored for halves; misaligned halves never reach here
    h = addr_lo[1] ? m[31:16] : m[15:0];
  end

  always_comb begin
    data = m;
    case (ld_op)
      LD_LB:  data = {{24{b[7]}}, b};
      LD_LBU: data = {24'h0, b};
      LD_LH:  data = {{16{h[15]}}, h};
      LD_LHU: data = {16'h0, h};
      LD_LWL: begin
        case (addr_lo)
          2'd0: data = {m[7:0],  r[23:0]};
          2'd1: data = {m[15:0], r[15:0]};
          2'd2: data = {m[23:0], r[7:0]};
          default: data = m;
        endcase
      end
      LD_LWR: begin
        case (addr_lo)
          2'd1: data = {r[31:24], m[31:8]};
          2'd2: data = {r[31:16], m[31:16]};
          2'd3: data = {r[31:8],  m[31:24]};
          default: data = m;
        endcase
      end
      default: data = m;
    endcase
  end

endmodule

// File: rtl/wb_load_stage.sv
// Writeback stage feeding the register-file write port.
// Accepts retiring MEM-stage results, waits for the data-memory response on
// loads, aligns/merges load data and emits one registered write per instruction.
//   clk, resetn        : clock, synchronous active-low reset
//   in_valid/in_ready  : MEM-stage handshake
//   in_wreg/in_waddr/in_wdata : write request (in_wdata = old rt for loads)
//   in_is_load/in_ld_op/in_addr_lo : load descriptor
//   mem_rsp_valid/mem_rdata : data-memory read response
//   flush              : squash anything not yet registered for write
//   wreg/waddr/wdata   : register-file write port (wreg is a one-cycle pulse)
//   load_busy          : a load is outstanding or being drained
//
// state    | meaning
// ST_IDLE  | ready for a new instruction
// ST_WAIT  | load accepted, waiting for memory response
// ST_DRAIN | load flushed, swallowing the response still owed
module wb_load_stage
  import wb_load_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_wreg,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic               in_is_load,
  input  logic [2:0]         in_ld_op,
  input  logic [1:0]         in_addr_lo,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               flush,
  output logic               wreg,
  output logic [RADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic               load_busy
);

  wb_state_e          state_q, state_d;
  logic               wreg_q, wreg_d;
  logic [RADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic               hold_wreg_q, hold_wreg_d;
  logic [RADDR_W-1:0] hold_waddr_q, hold_waddr_d;
  logic [DATA_W-1:0]  hold_rt_q, hold_rt_d;
  logic [2:0]         hold_op_q, hold_op_d;
  logic [1:0]         hold_lo_q, hold_lo_d;

  logic [DATA_W-1:0]  load_data;
  logic               accept;

  wb_load_stage_load_align u_align (
    .ld_op   (hold_op_q),
    .addr_lo (hold_lo_q),
    .m       (mem_rdata),
    .r       (hold_rt_q),
    .data    (load_data)
  );

  assign in_ready  = (resetn != RstEnable) && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign load_busy = (state_q != ST_IDLE);

  assign wreg  = wreg_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  always_comb begin
    state_d      = state_q;
    wreg_d       = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    hold_wreg_d  = hold_wreg_q;
    hold_waddr_d = hold_waddr_q;
    hold_rt_d    = hold_rt_q;
    hold_op_d    = hold_op_q;
    hold_lo_d    = hold_lo_q;

    case (state_q)
      ST_IDLE: begin
        // A response seen here is stale (or same-cycle with the accept) and is ignored
        if (accept) begin
          if (in_is_load) begin
            hold_wreg_d  = in_wreg;
            hold_waddr_d = in_waddr;
            hold_rt_d    = in_wdata;
            hold_op_d    = in_ld_op;
            hold_lo_d    = in_addr_lo;
            state_d      = ST_WAIT;
          end else begin
            wreg_d  = (in_wreg && (in_waddr != '0)) ? WriteEnable : 1'b0;
            waddr_d = in_waddr;
            wdata_d = in_wdata;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ST_IDLE;
          if (!flush) begin
            wreg_d  = (hold_wreg_q && (hold_waddr_q != '0)) ? WriteEnable : 1'b0;
            waddr_d = hold_waddr_q;
            wdata_d = load_data;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_rsp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn == RstEnable) begin
      state_q      <= ST_IDLE;
      wreg_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= ZeroWord;
      hold_wreg_q  <= 1'b0;
      hold_waddr_q <= '0;
      hold_rt_q    <= ZeroWord;
      hold_op_q    <= 3'd0;
      hold_lo_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      wreg_q       <= wreg_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      hold_wreg_q  <= hold_wreg_d;
      hold_waddr_q <= hold_waddr_d;
      hold_rt_q    <= hold_rt_d;
      hold_op_q    <= hold_op_d;
      hold_lo_q    <= hold_lo_d;
    end
  end

endmodule

// File: tb/tb_wb_load_stage.sv
module tb_wb_load_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        in_wreg;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        in_is_load;
  logic [2:0]  in_ld_op;
  logic [1:0]  in_addr_lo;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        wreg;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        load_busy;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  wb_load_stage dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg(in_wreg), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_is_load(in_is_load), .in_ld_op(in_ld_op), .in_addr_lo(in_addr_lo),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .flush(flush),
    .wreg(wreg), .waddr(waddr), .wdata(wdata), .load_busy(load_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (wreg === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: waddr=%0d wdata=0x%08h at %0t", waddr, wdata, $time);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("wr_addr", {27'h0, waddr}, {27'h0, e[36:32]});
        chk("wr_data", wdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    in_valid = 0; in_wreg = 0; in_waddr = 0; in_wdata = 0; in_is_load = 0;
    in_ld_op = 0; in_addr_lo = 0; mem_rsp_valid = 0; mem_rdata = 0; flush = 0;
  endtask

  task automatic send_alu(input logic [4:0] a, input logic [31:0] d, input logic wr);
    chk("alu_in_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1; in_is_load = 0; in_wreg = wr; in_waddr = a; in_wdata = d;
    if (wr && a != 0) sb_q.push_back({a, d});
    @(posedge clk); #1;
    in_valid = 0; in_wreg = 0;
  endtask

  // Load accepted at edge N, response at edge N+delay (delay >= 1)
  task automatic send_load(input logic [2:0] op, input logic [1:0] lo, input logic [4:0] a,
                           input logic [31:0] r, input logic [31:0] m, input int delay,
                           input logic [31:0] exp);
    chk("ld_in_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1; in_is_load = 1; in_wreg = 1; in_waddr = a; in_wdata = r;
    in_ld_op = op; in_addr_lo = lo;
    @(posedge clk); #1;
    in_valid = 0; in_is_load = 0; in_wreg = 0;
    repeat (delay - 1) begin
      @(negedge clk);
      chk("wait_busy", {31'h0, load_busy}, 32'h1);
      chk("wait_ready", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    sb_q.push_back({a, exp});
    mem_rsp_valid = 1; mem_rdata = m;
    @(negedge clk);
    chk("rsp_busy", {31'h0, load_busy}, 32'h1);
    @(posedge clk); #1;
    mem_rsp_valid = 0; mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("post_busy", {31'h0, load_busy}, 32'h0);
    chk("post_ready", {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_busy", {31'h0, load_busy}, 32'h0);
    chk("rst_wreg", {31'h0, wreg}, 32'h0);
    chk("rst_waddr", {27'h0, waddr}, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    resetn = 1;
    #1;

    // ADDU $3 and single-cycle pulse
    send_alu(5'd3, 32'h1234_5678, 1'b1);
    chk("addu_wreg", {31'h0, wreg}, 32'h1);
    chk("addu_waddr", {27'h0, waddr}, 32'd3);
    chk("addu_wdata", wdata, 32'h1234_5678);
    @(posedge clk); #1;
    chk("addu_wreg_drop", {31'h0, wreg}, 32'h0);

    // Back-to-back non-loads
    in_valid = 1; in_wreg = 1; in_waddr = 5'd7; in_wdata = 32'hA5A5_0001;
    sb_q.push_back({5'd7, 32'hA5A5_0001});
    @(posedge clk); #1;
    in_waddr = 5'd8; in_wdata = 32'hA5A5_0002;
    sb_q.push_back({5'd8, 32'hA5A5_0002});
    @(posedge clk); #1;
    in_valid = 0; in_wreg = 0;
    @(posedge clk); #1;

    // Byte/half/word extraction
    send_load(3'd0, 2'd2, 5'd4, 32'h0, 32'h00F0_0000, 1, 32'hFFFF_FFF0);
    send_load(3'd1, 2'd2, 5'd5, 32'h0, 32'h00F0_0000, 1, 32'h0000_00F0);
    send_load(3'd3, 2'd2, 5'd6, 32'h0, 32'h8001_0000, 1, 32'h0000_8001);
    send_load(3'd2, 2'd2, 5'd6, 32'h0, 32'h8001_0000, 1, 32'hFFFF_8001);
    send_load(3'd0, 2'd0, 5'd9, 32'h0, 32'h0000_007F, 1, 32'h0000_007F);
    send_load(3'd4, 2'd3, 5'd10, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    send_load(3'd7, 2'd2, 5'd10, 32'h0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);

    // LWL / LWR merge
    send_load(3'd5, 2'd1, 5'd11, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hCCDD_3344);
    send_load(3'd6, 2'd1, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'h11AA_BBCC);
    send_load(3'd5, 2'd0, 5'd11, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hDD22_3344);
    send_load(3'd5, 2'd3, 5'd11, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hAABB_CCDD);
    send_load(3'd6, 2'd2, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'h1122_AABB);
    send_load(3'd6, 2'd3, 5'd12, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'h1122_33AA);

    // Response delayed 3 cycles
    send_load(3'd4, 2'd0, 5'd13, 32'h0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D);

    // Same-cycle response at accept is not consumed
    in_valid = 1; in_is_load = 1; in_wreg = 1; in_waddr = 5'd14; in_ld_op = 3'd4;
    in_addr_lo = 0; mem_rsp_valid = 1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    in_valid = 0; in_is_load = 0; in_wreg = 0; mem_rsp_valid = 0;
    @(negedge clk);
    chk("early_rsp_busy", {31'h0, load_busy}, 32'h1);
    sb_q.push_back({5'd14, 32'h2222_2222});
    mem_rsp_valid = 1; mem_rdata = 32'h2222_2222;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    @(posedge clk); #1;

    // Flush in WAIT, response 2 cycles later
    in_valid = 1; in_is_load = 1; in_wreg = 1; in_waddr = 5'd15; in_ld_op = 3'd4;
    @(posedge clk); #1;
    in_valid = 0; in_is_load = 0; in_wreg = 0; flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("drain_busy", {31'h0, load_busy}, 32'h1);
    chk("drain_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    mem_rsp_valid = 1; mem_rdata = 32'h3333_3333;
    @(negedge clk);
    chk("drain_ready_rsp", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    @(negedge clk);
    chk("drain_done_ready", {31'h0, in_ready}, 32'h1);
    chk("drain_done_busy", {31'h0, load_busy}, 32'h0);

    // Flush in WAIT together with response: discarded
    in_valid = 1; in_is_load = 1; in_wreg = 1; in_waddr = 5'd16;
    @(posedge clk); #1;
    in_valid = 0; in_is_load = 0; in_wreg = 0;
    flush = 1; mem_rsp_valid = 1; mem_rdata = 32'h4444_4444;
    @(posedge clk); #1;
    flush = 0; mem_rsp_valid = 0;
    @(negedge clk);
    chk("flush_rsp_busy", {31'h0, load_busy}, 32'h0);

    // Flush in IDLE drops the same-cycle input
    in_valid = 1; in_wreg = 1; in_waddr = 5'd17; in_wdata = 32'h5555_5555; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; in_wreg = 0; flush = 0;
    chk("idle_flush_wreg", {31'h0, wreg}, 32'h0);

    // Flush does not cancel an already-registered write
    send_alu(5'd18, 32'h6666_6666, 1'b1);
    flush = 1;
    @(negedge clk);
    chk("flush_keep_wreg", {31'h0, wreg}, 32'h1);
    @(posedge clk); #1;
    flush = 0;

    // Destination $0 never writes
    send_alu(5'd0, 32'h7777_7777, 1'b1);
    chk("r0_wreg", {31'h0, wreg}, 32'h0);

    // Reset mid-WAIT, then stray response
    in_valid = 1; in_is_load = 1; in_wreg = 1; in_waddr = 5'd19; in_ld_op = 3'd4;
    @(posedge clk); #1;
    in_valid = 0; in_is_load = 0; in_wreg = 0;
    resetn = 0;
    @(posedge clk); #1;
    chk("midrst_busy", {31'h0, load_busy}, 32'h0);
    chk("midrst_wreg", {31'h0, wreg}, 32'h0);
    chk("midrst_waddr", {27'h0, waddr}, 32'h0);
    resetn = 1;
    mem_rsp_valid = 1; mem_rdata = 32'h8888_8888;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    chk("stray_busy", {31'h0, load_busy}, 32'h0);
    chk("stray_ready", {31'h0, in_ready}, 32'h1);
    chk("stray_wreg", {31'h0, wreg}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
